loop_ctrl: RTL and testbench

LOOP_CTRL -- requirements
Module: loop_ctrl

---
 rtl/loop_ctrl_if.sv | 19 +
 rtl/loop_ctrl.sv | 99 +++++++++
 tb/tb_loop_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/loop_ctrl_if.sv
// loop_ctrl_if: row issue handshake and loop index bus
// master: drives row_vld, idx_row/blk/frm/pat/lay and last_row; samples row_rdy
// slave:  samples the row bus; drives row_rdy
interface loop_ctrl_if #(
  parameter int ROW_W = 5,
  parameter int BLK_W = 6,
  parameter int FRM_W = 4,
  parameter int PAT_W = 4,
  parameter int LAY_W = 4
);
  logic row_vld, row_rdy, last_row;
  logic [ROW_W-1:0] idx_row;
  logic [BLK_W-1:0] idx_blk;
  logic [FRM_W-1:0] idx_frm;
  logic [PAT_W-1:0] idx_pat;
  logic [LAY_W-1:0] idx_lay;
  modport master(output row_vld, idx_row, idx_blk, idx_frm, idx_pat, idx_lay, last_row, input row_rdy);
  modport slave(input row_vld, idx_row, idx_blk, idx_frm, idx_pat, idx_lay, last_row, output row_rdy);
endinterface

// File: rtl/loop_ctrl.sv
// loop_ctrl: five-level odometer loop sequencer issuing one row per handshake
// clk/rst_n: clock and async active-low reset
// start/abort: run request (IDLE only) and run cancel (LOAD/RUN only)
// CFG_*: loop bounds, latched on start
// row: row handshake and current indices (master side)
// busy/done/cfg_err: status; done and cfg_err are one-cycle pulses
module loop_ctrl #(
  parameter int ROW_W = 5,
  parameter int BLK_W = 6,
  parameter int FRM_W = 4,
  parameter int PAT_W = 4,
  parameter int LAY_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] CFG_LenRow,
  input  logic [BLK_W-1:0] CFG_NumBlk,
  input  logic [FRM_W-1:0] CFG_NumFrm,
  input  logic [PAT_W-1:0] CFG_NumPat,
  input  logic [LAY_W-1:0] CFG_NumLay,
  loop_ctrl_if.master      row,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [ROW_W-1:0] len_row;
  logic [BLK_W-1:0] num_blk;
  logic [FRM_W-1:0] num_frm;
  logic [PAT_W-1:0] num_pat;
  logic [LAY_W-1:0] num_lay;
  logic xfer, w_row, w_blk, w_frm, w_pat, w_lay, fin, cfg_ok, adv;
  assign xfer = row.row_vld & row.row_rdy;
  // counts are known non-zero in RUN, so count-1 never underflows there
  assign w_row = row.idx_row == len_row;
  assign w_blk = row.idx_blk == num_blk - BLK_W'(1);
  assign w_frm = row.idx_frm == num_frm - FRM_W'(1);
  assign w_pat = row.idx_pat == num_pat - PAT_W'(1);
  assign w_lay = row.idx_lay == num_lay - LAY_W'(1);
  assign fin = w_row & w_blk & w_frm & w_pat & w_lay;
  assign cfg_ok = (|num_blk) & (|num_frm) & (|num_pat) & (|num_lay);
  assign adv = (state == RUN) & xfer & ~abort & ~fin;
  assign row.row_vld = state == RUN;
  // gated so every output reads 0 out of reset and between runs
  assign row.last_row = (state == RUN) & w_row;
  assign busy = (state == LOAD) | (state == RUN);
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? LOAD : IDLE;
      LOAD: state_nxt = (!abort && cfg_ok) ? RUN : IDLE;
      RUN:  state_nxt = abort ? IDLE : (xfer && fin) ? DONE : RUN;
      DONE: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cfg_err <= 1'b0;
      len_row <= '0;
      num_blk <= '0;
      num_frm <= '0;
      num_pat <= '0;
      num_lay <= '0;
      row.idx_row <= '0;
      row.idx_blk <= '0;
      row.idx_frm <= '0;
      row.idx_pat <= '0;
      row.idx_lay <= '0;
    end else begin
      state <= state_nxt;
      cfg_err <= (state == LOAD) & ~abort & ~cfg_ok;
      if (state == IDLE && start) begin
        len_row <= CFG_LenRow;
        num_blk <= CFG_NumBlk;
        num_frm <= CFG_NumFrm;
        num_pat <= CFG_NumPat;
        num_lay <= CFG_NumLay;
      end
      if (state == LOAD) begin
        row.idx_row <= '0;
        row.idx_blk <= '0;
        row.idx_frm <= '0;
        row.idx_pat <= '0;
        row.idx_lay <= '0;
      end else if (adv) begin
        row.idx_row <= w_row ? '0 : row.idx_row + ROW_W'(1);
        if (w_row) row.idx_blk <= w_blk ? '0 : row.idx_blk + BLK_W'(1);
        if (w_row && w_blk) row.idx_frm <= w_frm ? '0 : row.idx_frm + FRM_W'(1);
        if (w_row && w_blk && w_frm) row.idx_pat <= w_pat ? '0 : row.idx_pat + PAT_W'(1);
        if (w_row && w_blk && w_frm && w_pat) row.idx_lay <= w_lay ? '0 : row.idx_lay + LAY_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl: scoreboard bench for loop_ctrl
module tb_loop_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tog = 1'b0;
  logic [4:0] len;
  logic [5:0] nb;
  logic [3:0] nf, np, nl;
  logic busy, done, cfg_err;
  int vec = 0, miss = 0;
  logic [33:0] q[$];
  logic [33:0] held;
  logic stalled = 1'b0, prev_xfer = 1'b0;
  loop_ctrl_if lif();
  loop_ctrl dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .CFG_LenRow(len), .CFG_NumBlk(nb), .CFG_NumFrm(nf), .CFG_NumPat(np), .CFG_NumLay(nl),
    .row(lif), .busy(busy), .done(done), .cfg_err(cfg_err));
  always #5 clk = ~clk;
  initial begin
    lif.row_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 lif.row_rdy = tog ? ~lif.row_rdy : 1'b1;
    end
  end
  task automatic chk(input string nm, input logic [33:0] a, input logic [33:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [33:0] cur();
    return {2'd0, 8'd0, lif.idx_lay, lif.idx_pat, lif.idx_frm, lif.idx_blk, lif.idx_row, lif.last_row};
  endfunction
  function automatic logic [33:0] pk(int lay, int pat, int frm, int blk, int r, int last);
    return {2'd0, 8'd0, 4'(lay), 4'(pat), 4'(frm), 6'(blk), 5'(r), 1'(last)};
  endfunction
  localparam logic [33:0] E_DONE = {2'd1, 32'd0};
  localparam logic [33:0] E_CERR = {2'd2, 32'd0};
  function automatic logic [33:0] all_out();
    return {2'd0, 4'd0, busy, done, cfg_err, lif.row_vld, cur()};
  endfunction
  // monitor: samples on the falling edge, pops the scoreboard on each event
  always @(negedge clk) if (rst_n) begin
    if (stalled && lif.row_vld) chk("stall_hold", cur(), held);
    if (lif.row_vld && lif.row_rdy) begin
      if (q.size() == 0) begin vec++; miss++; $display("FAIL xfer: unexpected transfer %h", cur()); end
      else chk("xfer", cur(), q.pop_front());
    end
    if (done) begin
      chk("done_after_xfer", {33'd0, prev_xfer}, 34'd1);
      if (q.size() == 0) begin vec++; miss++; $display("FAIL done: unexpected done pulse"); end
      else chk("done", E_DONE, q.pop_front());
    end
    if (cfg_err) begin
      if (q.size() == 0) begin vec++; miss++; $display("FAIL cfg_err: unexpected pulse"); end
      else chk("cfg_err", E_CERR, q.pop_front());
    end
    stalled = lif.row_vld && !lif.row_rdy;
    held = cur();
    prev_xfer = lif.row_vld && lif.row_rdy;
  end
  task automatic push_run(int ln, int b, int f, int p, int l);
    for (int a = 0; a < l; a++)
      for (int c = 0; c < p; c++)
        for (int d = 0; d < f; d++)
          for (int e = 0; e < b; e++)
            for (int r = 0; r <= ln; r++) q.push_back(pk(a, c, d, e, r, r == ln));
    q.push_back(E_DONE);
  endtask
  task automatic cfg(int ln, int b, int f, int p, int l);
    len = 5'(ln); nb = 6'(b); nf = 4'(f); np = 4'(p); nl = 4'(l);
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
    chk("idle_timeout", {33'd0, busy}, 34'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    cfg(1, 2, 1, 1, 2);
    #3 chk("reset_outputs", all_out(), 34'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("no_autostart", {33'd0, busy}, 34'd0);
    // run 1: hand table of (lay,blk,row) 000..111, row_rdy constant
    for (int i = 0; i < 8; i++) q.push_back(pk(i / 4, 0, 0, (i / 2) % 2, i % 2, i % 2));
    q.push_back(E_DONE);
    pulse_start();
    chk("load_busy", {32'd0, busy, lif.row_vld}, 34'b10);
    @(posedge clk); #1 chk("run_vld", {33'd0, lif.row_vld}, 34'd1);
    wait_idle();
    // run 2: row_rdy toggling
    push_run(1, 2, 1, 1, 2);
    tog = 1'b1;
    pulse_start();
    wait_idle();
    tog = 1'b0;
    // zero block count
    cfg(1, 0, 1, 1, 2);
    q.push_back(E_CERR);
    pulse_start();
    chk("cerr_load", {32'd0, busy, cfg_err}, 34'b10);
    @(posedge clk); #1 chk("cerr_pulse", {31'd0, busy, cfg_err, lif.row_vld}, 34'b010);
    @(posedge clk); #1 chk("cerr_gone", {31'd0, busy, cfg_err, lif.row_vld}, 34'b000);
    // abort at the third transfer, then replay
    cfg(1, 2, 1, 1, 2);
    for (int i = 0; i < 3; i++) q.push_back(pk(0, 0, 0, i / 2, i % 2, i % 2));
    pulse_start();
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle", {31'd0, busy, done, lif.row_vld}, 34'd0);
    @(posedge clk); #1 chk("abort_no_done", {33'd0, done}, 34'd0);
    push_run(1, 2, 1, 1, 2);
    pulse_start();
    wait_idle();
    // async reset mid-run
    for (int i = 0; i < 2; i++) q.push_back(pk(0, 0, 0, 0, i, i));
    pulse_start();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", all_out(), 34'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk("post_reset_quiet", {32'd0, busy, lif.row_vld}, 34'd0);
    end
    // start held, config changed mid-run
    push_run(1, 2, 1, 1, 2);
    push_run(0, 1, 1, 1, 1);
    @(posedge clk); #1 start = 1'b1;
    repeat (4) @(posedge clk);
    #1 cfg(0, 1, 1, 1, 1);
    for (int i = 0; i < 100 && !done; i++) begin @(posedge clk); #1; end
    chk("first_done", {33'd0, done}, 34'd1);
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    chk("second_load", {33'd0, busy}, 34'd1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("drain", 34'(q.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
